wb_itr_chk: RTL and testbench

Synthesizable, parametrised checker for a pipelined Wishbone initiator port that supports multiple outstanding requests.
- Tracks outstanding accepted requests, request-stall time and response latency.
- Records protocol violations as sticky flags and raises an interrupt.
- Taps an initiator/target link passively, with all bus ports as inputs; used in silicon debug builds and in benches.

---
 rtl/wb_itr_chk_pkg.sv | 26 ++
 rtl/wb_itr_chk_tmr.sv | 35 +++
 rtl/wb_itr_chk.sv | 194 +++++++++++++++++++
 tb/tb_wb_itr_chk.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_itr_chk_pkg.sv
// Shared types and constants for the Wishbone initiator checker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package wb_itr_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CYCLE = 2'b01,
        WAIT  = 2'b10
    } state_t;

    localparam int FLG_WIDTH    = 7;
    localparam int FLG_SPURIOUS = 0;
    localparam int FLG_MULTI    = 1;
    localparam int FLG_OVERFLOW = 2;
    localparam int FLG_CYC_DROP = 3;
    localparam int FLG_STB_WDRW = 4;
    localparam int FLG_UNSTABLE = 5;
    localparam int FLG_TIMEOUT  = 6;

    // True when at least two of the three termination signals are high.
    function automatic logic multi_hot(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/wb_itr_chk_tmr.sv
// Saturating event timer; hit pulses once when the count reaches LIMIT.
// Latency: hit is registered, high during the cycle the count equals LIMIT for the first time.
// Backpressure: none, passive.
// Ports: clk_i, async_rst_n_i (active-low async), run (count this cycle),
//        clr (return to zero, wins over run), hit (one-cycle pulse).
module wb_itr_chk_tmr #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic async_rst_n_i,
    input  logic run,
    input  logic clr,
    output logic hit
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) begin
            cnt <= '0;
            hit <= 1'b0;
        end else begin
            // Pulse only on the transition into LIMIT; holding at LIMIT
            // never re-arms it until a clear.
            hit <= run & ~clr & (cnt == W'(LIMIT - 1));
            if (clr) begin
                cnt <= '0;
            end else if (run && (cnt != W'(LIMIT))) begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/wb_itr_chk.sv
// Passive protocol checker for a pipelined Wishbone initiator with multiple outstanding requests.
// Latency: flags register one cycle after detection, chk_irq_o one cycle after the flags.
// Backpressure: none; all bus signals are observed only, nothing is driven onto the bus.
// Ports: clk_i, async_rst_n_i (active-low async); itr_* initiator controls and
//        target responses (itr_ack_o/err_o/rty_o/stall_o are inputs tapped from the link);
//        chk_clr_i clears sticky flags; chk_flags_o, chk_irq_o, chk_out_cnt_o.
// Build option: define WB_ITR_CHK_CAPTURE_EN to add first-error capture
//        outputs chk_cap_adr_o, chk_cap_we_o, chk_cap_flags_o, chk_cap_vld_o.
module wb_itr_chk
    import wb_itr_chk_pkg::*;
#(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int SEL_WIDTH = 2,
    parameter int TGA_WIDTH = 1,
    parameter int TGC_WIDTH = 1,
    parameter int MAX_OUT   = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk_i,
    input  logic                         async_rst_n_i,
    input  logic                         itr_cyc_i,
    input  logic                         itr_stb_i,
    input  logic                         itr_we_i,
    input  logic                         itr_lock_i,
    input  logic [SEL_WIDTH-1:0]         itr_sel_i,
    input  logic [ADR_WIDTH-1:0]         itr_adr_i,
    input  logic [TGA_WIDTH-1:0]         itr_tga_i,
    input  logic [TGC_WIDTH-1:0]         itr_tgc_i,
    input  logic                         itr_ack_o,
    input  logic                         itr_err_o,
    input  logic                         itr_rty_o,
    input  logic                         itr_stall_o,
    input  logic                         chk_clr_i,
    output logic [FLG_WIDTH-1:0]         chk_flags_o,
    output logic                         chk_irq_o,
`ifdef WB_ITR_CHK_CAPTURE_EN
    output logic [ADR_WIDTH-1:0]         chk_cap_adr_o,
    output logic                         chk_cap_we_o,
    output logic [FLG_WIDTH-1:0]         chk_cap_flags_o,
    output logic                         chk_cap_vld_o,
`endif
    output logic [$clog2(MAX_OUT+1)-1:0] chk_out_cnt_o
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam int CTL_W = 2 + SEL_WIDTH + ADR_WIDTH + TGA_WIDTH + TGC_WIDTH;

    if (MAX_OUT < 1 || TIMEOUT < 1 || DAT_WIDTH < 1) begin : g_bad_param
        $error("wb_itr_chk: MAX_OUT, TIMEOUT and DAT_WIDTH must be >= 1");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               req;
    logic               rsp;
    logic               retire;
    logic               ovf;
    logic               stall_now;
    logic               stall_q;
    logic [CTL_W-1:0]   ctl;
    logic [CTL_W-1:0]   ctl_q;
    logic               stall_hit;
    logic               rsp_hit;
    logic               rsp_run;
    logic [FLG_WIDTH-1:0] det;
    logic [FLG_WIDTH-1:0] flags_q;
    logic [FLG_WIDTH-1:0] flags_nxt;

    assign req       = itr_cyc_i & itr_stb_i & ~itr_stall_o;
    assign rsp       = itr_ack_o | itr_err_o | itr_rty_o;
    assign stall_now = itr_cyc_i & itr_stb_i & itr_stall_o;
    assign ctl       = {itr_we_i, itr_lock_i, itr_sel_i, itr_adr_i, itr_tga_i, itr_tgc_i};

    // A response only retires requests accepted in earlier cycles, so a
    // response with count 0 is spurious even if a request lands alongside it.
    always_comb begin
        cnt_nxt = cnt_q;
        ovf     = 1'b0;
        retire  = rsp & (cnt_q != '0);
        if (!itr_cyc_i) begin
            cnt_nxt = '0;
        end else if (req && !retire) begin
            if (cnt_q == CNT_W'(MAX_OUT)) begin
                ovf = 1'b1;
            end else begin
                cnt_nxt = cnt_q + CNT_W'(1);
            end
        end else if (retire && !req) begin
            cnt_nxt = cnt_q - CNT_W'(1);
        end
    end

    // WAIT is held exactly while the registered count is non-zero.
    always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
            case (state)
                IDLE:    if (itr_cyc_i) state <= (cnt_nxt != '0) ? WAIT : CYCLE;
                CYCLE:   if (!itr_cyc_i) state <= IDLE;
                         else if (req)   state <= WAIT;
                WAIT:    if (!itr_cyc_i) state <= IDLE;
                         else if (cnt_nxt == '0) state <= CYCLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Previous-cycle stall and control snapshot for the stalled-request
    // stability checks.
    always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) begin
            stall_q <= 1'b0;
            ctl_q   <= '0;
        end else begin
            stall_q <= stall_now;
            ctl_q   <= ctl;
        end
    end

    assign rsp_run = (state == WAIT) & ~rsp;

    wb_itr_chk_tmr #(.LIMIT(TIMEOUT)) u_stall_tmr (
        .clk_i         (clk_i),
        .async_rst_n_i (async_rst_n_i),
        .run           (stall_now),
        .clr           (~stall_now),
        .hit           (stall_hit)
    );

    wb_itr_chk_tmr #(.LIMIT(TIMEOUT)) u_rsp_tmr (
        .clk_i         (clk_i),
        .async_rst_n_i (async_rst_n_i),
        .run           (rsp_run),
        .clr           (~rsp_run),
        .hit           (rsp_hit)
    );

    always_comb begin
        det               = '0;
        det[FLG_SPURIOUS] = rsp & (cnt_q == '0);
        det[FLG_MULTI]    = itr_cyc_i & multi_hot(itr_ack_o, itr_err_o, itr_rty_o);
        det[FLG_OVERFLOW] = ovf;
        det[FLG_CYC_DROP] = ~itr_cyc_i & (state == WAIT);
        det[FLG_STB_WDRW] = itr_cyc_i & stall_q & ~itr_stb_i;
        det[FLG_UNSTABLE] = itr_cyc_i & stall_q & itr_stb_i & (ctl != ctl_q);
        det[FLG_TIMEOUT]  = stall_hit | rsp_hit;
    end

    // A detection in the clearing cycle survives the clear.
    assign flags_nxt = (chk_clr_i ? '0 : flags_q) | det;

    always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) begin
            flags_q   <= '0;
            chk_irq_o <= 1'b0;
        end else begin
            flags_q   <= flags_nxt;
            chk_irq_o <= |flags_q;
        end
    end

    assign chk_flags_o   = flags_q;
    assign chk_out_cnt_o = cnt_q;

`ifdef WB_ITR_CHK_CAPTURE_EN
    logic [FLG_WIDTH-1:0] new_bits;
    assign new_bits = flags_nxt & ~flags_q;

    // Freeze the context of the first error until software clears it.
    always_ff @(posedge clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) begin
            chk_cap_adr_o   <= '0;
            chk_cap_we_o    <= 1'b0;
            chk_cap_flags_o <= '0;
            chk_cap_vld_o   <= 1'b0;
        end else begin
            if (chk_clr_i) begin
                chk_cap_vld_o <= 1'b0;
            end
            if (!chk_cap_vld_o && (|new_bits)) begin
                chk_cap_adr_o   <= itr_adr_i;
                chk_cap_we_o    <= itr_we_i;
                chk_cap_flags_o <= new_bits;
                chk_cap_vld_o   <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_itr_chk.sv
// Directed bench for wb_itr_chk with MAX_OUT=4 and TIMEOUT=8.
// Latency: inputs change 1ns after a rising edge, outputs are read at the same point.
// Backpressure: n/a.
module tb_wb_itr_chk;
    logic        clk_i = 1'b0;
    logic        async_rst_n_i = 1'b0;
    logic        itr_cyc_i = 1'b0, itr_stb_i = 1'b0, itr_we_i = 1'b0, itr_lock_i = 1'b0;
    logic [1:0]  itr_sel_i = 2'b00;
    logic [15:0] itr_adr_i = 16'h0;
    logic [0:0]  itr_tga_i = 1'b0, itr_tgc_i = 1'b0;
    logic        itr_ack_o = 1'b0, itr_err_o = 1'b0, itr_rty_o = 1'b0, itr_stall_o = 1'b0;
    logic        chk_clr_i = 1'b0;
    logic [6:0]  chk_flags_o;
    logic        chk_irq_o;
    logic [2:0]  chk_out_cnt_o;
`ifdef WB_ITR_CHK_CAPTURE_EN
    logic [15:0] chk_cap_adr_o;
    logic        chk_cap_we_o;
    logic [6:0]  chk_cap_flags_o;
    logic        chk_cap_vld_o;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    wb_itr_chk #(
        .ADR_WIDTH(16), .DAT_WIDTH(16), .SEL_WIDTH(2), .TGA_WIDTH(1), .TGC_WIDTH(1),
        .MAX_OUT(4), .TIMEOUT(8)
    ) dut (
        .clk_i         (clk_i),
        .async_rst_n_i (async_rst_n_i),
        .itr_cyc_i     (itr_cyc_i),
        .itr_stb_i     (itr_stb_i),
        .itr_we_i      (itr_we_i),
        .itr_lock_i    (itr_lock_i),
        .itr_sel_i     (itr_sel_i),
        .itr_adr_i     (itr_adr_i),
        .itr_tga_i     (itr_tga_i),
        .itr_tgc_i     (itr_tgc_i),
        .itr_ack_o     (itr_ack_o),
        .itr_err_o     (itr_err_o),
        .itr_rty_o     (itr_rty_o),
        .itr_stall_o   (itr_stall_o),
        .chk_clr_i     (chk_clr_i),
        .chk_flags_o   (chk_flags_o),
        .chk_irq_o     (chk_irq_o),
`ifdef WB_ITR_CHK_CAPTURE_EN
        .chk_cap_adr_o   (chk_cap_adr_o),
        .chk_cap_we_o    (chk_cap_we_o),
        .chk_cap_flags_o (chk_cap_flags_o),
        .chk_cap_vld_o   (chk_cap_vld_o),
`endif
        .chk_out_cnt_o (chk_out_cnt_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if ({chk_flags_o, chk_irq_o, chk_out_cnt_o} !== 11'h0) $display("FAIL reset_outputs got flags=%b irq=%b cnt=%0d want all 0", chk_flags_o, chk_irq_o, chk_out_cnt_o);
        else n_pass++;
        tick();
        async_rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_cnt [5] = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd0};
        logic [15:0] adrs [3] = '{16'h10, 16'h12, 16'h14};
        itr_cyc_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            itr_stb_i = (i < 3);
            if (i < 3) itr_adr_i = adrs[i];
            itr_ack_o = (i >= 2);
            tick();
            n_total++;
            if (chk_out_cnt_o !== exp_cnt[i]) $display("FAIL b2b_cnt[%0d] got %0d want %0d", i, chk_out_cnt_o, exp_cnt[i]);
            else n_pass++;
        end
        itr_ack_o = 1'b0;
        itr_cyc_i = 1'b0;
        tick();
        n_total++;
        if (chk_flags_o !== 7'h00 || chk_irq_o !== 1'b0) $display("FAIL b2b_flags got flags=%b irq=%b want 0/0", chk_flags_o, chk_irq_o);
        else n_pass++;
    endtask

    task automatic test_overflow();
        itr_cyc_i = 1'b1; itr_stb_i = 1'b1; itr_adr_i = 16'h40;
        repeat (4) tick();
        n_total++;
        if (chk_out_cnt_o !== 3'd4 || chk_flags_o !== 7'h00) $display("FAIL ovf_fill got cnt=%0d flags=%b want 4/0", chk_out_cnt_o, chk_flags_o);
        else n_pass++;
        tick();
        n_total++;
        if (chk_flags_o !== 7'b0000100 || chk_irq_o !== 1'b0 || chk_out_cnt_o !== 3'd4) $display("FAIL ovf_flag got flags=%b irq=%b cnt=%0d want 0000100/0/4", chk_flags_o, chk_irq_o, chk_out_cnt_o);
        else n_pass++;
        itr_stb_i = 1'b0; itr_ack_o = 1'b1;
        tick();
        n_total++;
        if (chk_irq_o !== 1'b1 || chk_out_cnt_o !== 3'd3) $display("FAIL ovf_irq got irq=%b cnt=%0d want 1/3", chk_irq_o, chk_out_cnt_o);
        else n_pass++;
        repeat (3) tick();
        itr_ack_o = 1'b0; chk_clr_i = 1'b1;
        tick();
        chk_clr_i = 1'b0;
        n_total++;
        if (chk_flags_o !== 7'h00 || chk_out_cnt_o !== 3'd0) $display("FAIL ovf_clear got flags=%b cnt=%0d want 0/0", chk_flags_o, chk_out_cnt_o);
        else n_pass++;
        tick();
        n_total++;
        if (chk_irq_o !== 1'b0) $display("FAIL ovf_irq_clear got %b want 0", chk_irq_o);
        else n_pass++;
        itr_cyc_i = 1'b0;
        tick();
    endtask

    task automatic test_spurious_multi();
        itr_cyc_i = 1'b1; itr_ack_o = 1'b1;
        tick();
        n_total++;
        if (chk_flags_o !== 7'b0000001) $display("FAIL spur_flag got %b want 0000001", chk_flags_o);
        else n_pass++;
        itr_ack_o = 1'b0;
        tick();
        n_total++;
        if (chk_irq_o !== 1'b1) $display("FAIL spur_irq got %b want 1", chk_irq_o);
        else n_pass++;
        chk_clr_i = 1'b1; itr_ack_o = 1'b1;
        tick();
        n_total++;
        if (chk_flags_o !== 7'b0000001) $display("FAIL clr_vs_detect got %b want 0000001", chk_flags_o);
        else n_pass++;
        itr_ack_o = 1'b0;
        tick();
        chk_clr_i = 1'b0;
        n_total++;
        if (chk_flags_o !== 7'h00) $display("FAIL spur_clear got %b want 0", chk_flags_o);
        else n_pass++;
        itr_stb_i = 1'b1;
        tick();
        itr_stb_i = 1'b0; itr_ack_o = 1'b1; itr_err_o = 1'b1;
        tick();
        n_total++;
        if (chk_flags_o !== 7'b0000010 || chk_out_cnt_o !== 3'd0) $display("FAIL multi got flags=%b cnt=%0d want 0000010/0", chk_flags_o, chk_out_cnt_o);
        else n_pass++;
        itr_ack_o = 1'b0; itr_err_o = 1'b0; chk_clr_i = 1'b1;
        tick();
        chk_clr_i = 1'b0; itr_cyc_i = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        itr_cyc_i = 1'b1; itr_stb_i = 1'b1; itr_stall_o = 1'b1; itr_adr_i = 16'h20;
        tick();
        tick();
        n_total++;
        if (chk_flags_o !== 7'h00) $display("FAIL stall_stable got %b want 0", chk_flags_o);
        else n_pass++;
        itr_adr_i = 16'h22;
        tick();
        n_total++;
        if (chk_flags_o !== 7'b0100000) $display("FAIL unstable got %b want 0100000", chk_flags_o);
        else n_pass++;
        itr_stb_i = 1'b0;
        tick();
        n_total++;
        if (chk_flags_o !== 7'b0110000 || chk_out_cnt_o !== 3'd0) $display("FAIL stb_wdraw got flags=%b cnt=%0d want 0110000/0", chk_flags_o, chk_out_cnt_o);
        else n_pass++;
        itr_stall_o = 1'b0; chk_clr_i = 1'b1;
        tick();
        chk_clr_i = 1'b0; itr_cyc_i = 1'b0;
        tick();
        n_total++;
        if (chk_flags_o !== 7'h00) $display("FAIL stall_clear got %b want 0", chk_flags_o);
        else n_pass++;
    endtask

    task automatic test_timeout();
        itr_cyc_i = 1'b1; itr_stb_i = 1'b1; itr_adr_i = 16'h50;
        tick();
        itr_stb_i = 1'b0;
        repeat (8) tick();
        n_total++;
        if (chk_flags_o !== 7'h00) $display("FAIL tmo_early got %b want 0", chk_flags_o);
        else n_pass++;
        tick();
        n_total++;
        if (chk_flags_o !== 7'b1000000) $display("FAIL tmo_flag got %b want 1000000", chk_flags_o);
        else n_pass++;
        chk_clr_i = 1'b1;
        tick();
        chk_clr_i = 1'b0;
        repeat (3) tick();
        n_total++;
        if (chk_flags_o !== 7'h00 || chk_out_cnt_o !== 3'd1) $display("FAIL tmo_once got flags=%b cnt=%0d want 0/1", chk_flags_o, chk_out_cnt_o);
        else n_pass++;
        itr_cyc_i = 1'b0;
        tick();
        n_total++;
        if (chk_flags_o !== 7'b0001000 || chk_out_cnt_o !== 3'd0) $display("FAIL cyc_drop got flags=%b cnt=%0d want 0001000/0", chk_flags_o, chk_out_cnt_o);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        itr_cyc_i = 1'b1; itr_stb_i = 1'b1; itr_adr_i = 16'h60;
        repeat (3) tick();
        itr_stb_i = 1'b0;
        n_total++;
        if (chk_out_cnt_o !== 3'd3 || chk_irq_o !== 1'b1) $display("FAIL arst_pre got cnt=%0d irq=%b want 3/1", chk_out_cnt_o, chk_irq_o);
        else n_pass++;
        #2;
        async_rst_n_i = 1'b0;
        #1;
        n_total++;
        if ({chk_flags_o, chk_irq_o, chk_out_cnt_o} !== 11'h0) $display("FAIL arst_mid got flags=%b irq=%b cnt=%0d want all 0", chk_flags_o, chk_irq_o, chk_out_cnt_o);
        else n_pass++;
        itr_cyc_i = 1'b0;
        tick();
        async_rst_n_i = 1'b1;
        tick();
        n_total++;
        if (chk_flags_o !== 7'h00 || chk_out_cnt_o !== 3'd0) $display("FAIL arst_post got flags=%b cnt=%0d want 0/0", chk_flags_o, chk_out_cnt_o);
        else n_pass++;
    endtask

`ifdef WB_ITR_CHK_CAPTURE_EN
    task automatic test_capture();
        itr_cyc_i = 1'b1; itr_adr_i = 16'h30; itr_we_i = 1'b1; itr_ack_o = 1'b1;
        tick();
        n_total++;
        if (chk_cap_vld_o !== 1'b1 || chk_cap_adr_o !== 16'h30 || chk_cap_we_o !== 1'b1 || chk_cap_flags_o !== 7'b0000001)
            $display("FAIL cap_first got vld=%b adr=%h we=%b flags=%b want 1/0030/1/0000001", chk_cap_vld_o, chk_cap_adr_o, chk_cap_we_o, chk_cap_flags_o);
        else n_pass++;
        itr_adr_i = 16'h40; itr_we_i = 1'b0; itr_err_o = 1'b1;
        tick();
        n_total++;
        if (chk_cap_adr_o !== 16'h30 || chk_cap_flags_o !== 7'b0000001) $display("FAIL cap_hold got adr=%h flags=%b want 0030/0000001", chk_cap_adr_o, chk_cap_flags_o);
        else n_pass++;
        itr_ack_o = 1'b0; itr_err_o = 1'b0; itr_cyc_i = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_overflow();
        test_spurious_multi();
        test_stall();
        test_timeout();
        test_async_reset();
`ifdef WB_ITR_CHK_CAPTURE_EN
        test_capture();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
